// File: rtl/bus_ram.sv
// bus_ram: small word-wide RAM on a shared tristate system bus.
//
// A memory address register (MAR) and memory data register (MDR) are loaded
// from sysbus. A CS request runs a read (mem -> MDR) or write (MDR -> mem) at
// the address in MAR. Each access waits WAIT extra cycles before it executes.
// When MDR_bus is asserted, MDR is driven back onto sysbus.
//
// Ports
//   clock     in   single clock, rising edge
//   reset     in   synchronous active-high reset
//   MDR_bus   in   drive MDR onto sysbus (only when MAR hits and not busy)
//   load_MAR  in   MAR <= sysbus[ADDR_W-1:0]
//   load_MDR  in   MDR <= sysbus
//   CS        in   start an access at MAR
//   R_NW      in   1: read mem into MDR, 0: write MDR into mem
//   sysbus    io   shared tristate bus, WORD_W bits
//   ready     out  one-cycle pulse after the access edge
//   busy      out  high while an access is waiting/executing
//   err       out  one-cycle pulse after CS is accepted with MAR out of range
//
// State table
//   IDLE    | accepts load_MAR / load_MDR / CS
//   WAIT_ST | wait states counting down; access runs when the counter is 0
//   DONE    | ready cycle; accepts requests exactly like IDLE
module bus_ram #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 5,
  parameter int BASE   = 16,
  parameter int DEPTH  = 14,
  parameter int WAIT   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MDR_bus,
  input  logic              load_MAR,
  input  logic              load_MDR,
  input  logic              CS,
  input  logic              R_NW,
  inout  logic [WORD_W-1:0] sysbus,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Range bounds are one bit wider than MAR so BASE+DEPTH never wraps.
  localparam logic [ADDR_W:0]   BASE_X  = (ADDR_W+1)'(BASE);
  localparam logic [ADDR_W:0]   LIMIT_X = (ADDR_W+1)'(BASE + DEPTH);
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE);
  localparam logic [3:0]        WAIT_C  = 4'(WAIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_ST = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mar_q, mar_d;
  logic [WORD_W-1:0]   mdr_q, mdr_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                rnw_q, rnw_d;
  logic                err_q, err_d;
  logic                mem_we;

  logic [WORD_W-1:0]   mem [DEPTH];

  logic                hit;
  logic [IDX_W-1:0]    idx;

  assign hit = ({1'b0, mar_q} >= BASE_X) && ({1'b0, mar_q} < LIMIT_X);
  // Only meaningful when hit is true; out-of-range MAR never reaches memory.
  assign idx = IDX_W'(mar_q - BASE_A);

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    cnt_d   = cnt_q;
    rnw_d   = rnw_q;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      WAIT_ST: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          if (rnw_q) begin
            mdr_d = mem[idx];
          end else begin
            mem_we = 1'b1;
          end
        end
      end
      default: begin
        // IDLE and DONE behave identically apart from DONE's ready output.
        state_d = IDLE;
        if (load_MAR) begin
          mar_d = sysbus[ADDR_W-1:0];
        end else if (load_MDR) begin
          mdr_d = sysbus;
        end else if (CS) begin
          if (hit) begin
            rnw_d   = R_NW;
            cnt_d   = WAIT_C;
            state_d = WAIT_ST;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      cnt_q   <= '0;
      rnw_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
      rnw_q   <= rnw_d;
      err_q   <= err_d;
    end
  end

  // Storage has no reset; reset still blocks a write that lands on its edge.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem[idx] <= mdr_q;
    end
  end

  assign ready  = (state_q == DONE);
  assign busy   = (state_q == WAIT_ST);
  assign err    = err_q;
  assign sysbus = (MDR_bus && hit && !busy) ? mdr_q : 'z;

endmodule
